// File: rtl/inst_queue_if.sv
// inst_queue_if: fetch-side and decode-side handshake bundle for inst_queue.
// slave  = the queue itself, master = the fetch/decode stages driving it.
interface inst_queue_if #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic            flush_i;
   logic            if_valid_i;
   logic [XLEN-1:0] if_inst_i;
   logic [XLEN-1:0] if_pc_i;
   logic            if_ready_o;
   logic            id_valid_o;
   logic [XLEN-1:0] id_inst_o;
   logic [XLEN-1:0] id_pc_o;
   logic            id_ready_i;
   logic [CW-1:0]   count_o;

   modport slave (
      input  flush_i, if_valid_i, if_inst_i, if_pc_i, id_ready_i,
      output if_ready_o, id_valid_o, id_inst_o, id_pc_o, count_o
   );

   modport master (
      output flush_i, if_valid_i, if_inst_i, if_pc_i, id_ready_i,
      input  if_ready_o, id_valid_o, id_inst_o, id_pc_o, count_o
   );
endinterface

// File: rtl/inst_queue.sv
// inst_queue: circular instruction/PC buffer between fetch and decode.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Optional macro INST_QUEUE_BYPASS_EN: when the queue is empty an incoming
// fetch entry is forwarded combinationally to decode (zero-cycle latency).
module inst_queue #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input logic          clk_i,
   input logic          rst_i,
   inst_queue_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

   logic [PW-1:0]   wptr_reg, rptr_reg, count_reg;
   logic [PW-1:0]   count_next;
   logic [XLEN-1:0] mem_inst [DEPTH];
   logic [XLEN-1:0] mem_pc   [DEPTH];

   logic [AW-1:0]   widx, ridx;
   logic            full, empty;
   logic            bypass_hit;
   logic            push, pop, push_eff, pop_eff;
   logic            id_valid;
   logic [XLEN-1:0] id_inst, id_pc;

   assign widx  = wptr_reg[AW-1:0];
   assign ridx  = rptr_reg[AW-1:0];
   assign full  = (widx == ridx) && (wptr_reg[AW] != rptr_reg[AW]);
   assign empty = (wptr_reg == rptr_reg);

`ifdef INST_QUEUE_BYPASS_EN
   assign bypass_hit = empty & bus.if_valid_i & ~bus.flush_i;
`else
   assign bypass_hit = 1'b0;
`endif

   // ready never looks at id_ready_i, keeping decode off the fetch timing path
   assign bus.if_ready_o = ~full & ~bus.flush_i;

   // head entry to decode, forwarded fetch entry on bypass, NOP otherwise
   always_comb begin
      id_valid = 1'b0;
      id_inst  = NOP;
      id_pc    = '0;
      if (!empty && !bus.flush_i) begin
         id_valid = 1'b1;
         id_inst  = mem_inst[ridx];
         id_pc    = mem_pc[ridx];
      end else if (bypass_hit) begin
         id_valid = 1'b1;
         id_inst  = bus.if_inst_i;
         id_pc    = bus.if_pc_i;
      end
   end

   assign bus.id_valid_o = id_valid;
   assign bus.id_inst_o  = id_inst;
   assign bus.id_pc_o    = id_pc;
   assign bus.count_o    = count_reg;

   assign push = bus.if_valid_i & bus.if_ready_o;
   assign pop  = id_valid & bus.id_ready_i;
   // a bypassed entry consumed the same cycle never touches storage
   assign push_eff = push & ~(bypass_hit & bus.id_ready_i);
   assign pop_eff  = pop & ~bypass_hit;

   // occupancy follows pushes minus pops
   always_comb begin
      count_next = count_reg + {{AW{1'b0}}, push_eff} - {{AW{1'b0}}, pop_eff};
   end

   // pointers and occupancy; flush beats any handshake in the same cycle
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wptr_reg  <= '0;
         rptr_reg  <= '0;
         count_reg <= '0;
      end else if (bus.flush_i) begin
         wptr_reg  <= '0;
         rptr_reg  <= '0;
         count_reg <= '0;
      end else begin
         if (push_eff) wptr_reg <= wptr_reg + 1'b1;
         if (pop_eff)  rptr_reg <= rptr_reg + 1'b1;
         count_reg <= count_next;
      end
   end

   // per-entry storage write; contents are don't-care until pushed, so no reset
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk_i) begin
         if (push_eff && (widx == AW'(gi))) begin
            mem_inst[gi] <= bus.if_inst_i;
            mem_pc[gi]   <= bus.if_pc_i;
         end
      end
   end
endmodule

// File: doc/inst_queue.md
# inst_queue

Instruction queue between the fetch stage (`inst_fetch`) and the decode stage. Buffers up to DEPTH fetched instruction/PC pairs with valid/ready handshakes on both sides, so fetch keeps running while decode stalls. Provides a single-cycle flush for branch redirect. The downstream decode stage only ever sees valid instructions, or a NOP when the queue is empty.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; power of two, ≥2.
- `XLEN`, 32: width of instruction and PC.

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  reset; one clock; reset is asynchronous and active-low.
- `flush_i`  in  1  synchronous flush; discards all entries.
- `if_valid_i`  in  1  fetch presents an entry.
- `if_inst_i`  in  XLEN  fetched instruction.
- `if_pc_i`  in  XLEN  PC of fetched instruction.
- `if_ready_o`  out  1  queue can accept; push occurs when `if_valid_i & if_ready_o`.
- `id_valid_o`  out  1  head entry valid.
- `id_inst_o`  out  XLEN  head instruction; 32'h0000_0013 (NOP) when `id_valid_o`=0.
- `id_pc_o`  out  XLEN  head PC; 0 when `id_valid_o`=0.
- `id_ready_i`  in  1  decode accepts; pop occurs when `id_valid_o & id_ready_i`.
- `count_o`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- Storage: circular buffer of DEPTH entries {inst, pc}. Write and read pointers are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit. Full = index bits equal and MSB different. Empty = pointers equal.
- `if_ready_o` = !full & !flush_i. It does not depend on `id_ready_i`, so there is no combinational path from decode to fetch.
- `id_valid_o` = !empty & !flush_i (see Configuration for the bypass case).
- Push: write the entry at wptr and increment wptr, which wraps modulo 2·DEPTH.
- Pop: increment rptr.
- Simultaneous push and pop: both happen and count is unchanged.
- Full with pop in the same cycle: pop only; no push, because `if_ready_o` was 0.
- Flush: pointers and count return to 0 on the next edge. Any push or pop handshake presented in the flush cycle is ignored. Flush has priority over both.
- `count_o` is registered and tracks wptr−rptr.
- Storage array is not reset; only pointers are reset.

## Timing
- Reset state (asynchronous on `rst_i` low): wptr=rptr=0, `count_o`=0, `id_valid_o`=0, `id_inst_o`=32'h0000_0013, `id_pc_o`=0, `if_ready_o`=1.
- Latency, bypass off: an entry pushed at edge N appears on `id_*` after edge N, i.e. it is poppable in cycle N+1.
- Throughput: one push and one pop per cycle, sustained.
- Reset deasserted mid-operation: the queue restarts empty; entries in flight are lost.
- Outputs `id_*` and `if_ready_o` are combinational from pointers/flush/storage only, plus the bypass path when compiled in.

## Configuration
- `INST_QUEUE_BYPASS_EN` defined:
  - When the queue is empty, `if_valid_i`=1 and `flush_i`=0, the `id_*` outputs present `if_inst_i`/`if_pc_i` combinationally and `id_valid_o`=1.
  - If `id_ready_i`=1 the same cycle, the entry passes through without being written; pointers and count are unchanged. Latency is 0 cycles.
  - If `id_ready_i`=0, the entry is written normally.
- Undefined: no fetch→decode combinational path. Minimum latency is 1 cycle, as described above.

## Test plan
- Reset: hold `rst_i`=0, then release.
  - Required: `count_o`=0, `id_valid_o`=0, `id_inst_o`=0x00000013, `if_ready_o`=1.
- Fill with decode stalled: `id_ready_i`=0; push pc 0x0,0x4,0x8,0xC (DEPTH=4).
  - Required: after 4 edges `count_o`=4 and `if_ready_o`=0.
  - Required: a 5th push is not accepted.
  - Required: `id_pc_o` holds 0x0.
- Drain in order: from full, `id_ready_i`=1, no push.
  - Required: `id_pc_o` sequence is 0x0,0x4,0x8,0xC.
  - Required: `count_o` steps 3,2,1,0, then `id_valid_o`=0.
- Wrap and streaming: push and pop every cycle for 20 cycles with count held at 2.
  - Required: PCs emerge in order across pointer wrap, with `count_o` constant at 2.
- Flush: with count=3, assert `flush_i` together with `if_valid_i`=1 and `id_ready_i`=1.
  - Required: `id_valid_o`=0 and `if_ready_o`=0 in that cycle.
  - Required: next cycle `count_o`=0 and no entry is delivered.
- Bypass (`INST_QUEUE_BYPASS_EN` defined): with the queue empty, push 0x00500093 at pc 0x40 with `id_ready_i`=1.
  - Required: same cycle `id_valid_o`=1, `id_inst_o`=0x00500093, `id_pc_o`=0x40.
  - Required: next cycle `count_o`=0.
